jtframe_mister_upld: RTL and testbench

JTFRAME_MISTER_UPLD -- requirements
Module: jtframe_mister_upld

---
 rtl/jtframe_mister_pkg.sv | 13 +
 rtl/jtframe_mister_upld.sv | 116 +++++++++++
 tb/tb_jtframe_mister_upld.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_mister_pkg.sv
// Constants shared by the MiSTer HPS download and upload blocks.
// Menu index values select which core memory the HPS transfer targets.
package jtframe_mister_pkg;

    localparam logic [7:0] IDX_ROM   = 8'd0;
    localparam logic [7:0] IDX_MOD   = 8'd1;
    localparam logic [7:0] IDX_NVRAM = 8'd2;
    localparam logic [7:0] IDX_DIPSW = 8'd254;

    // Byte returned to the HPS when no real data is available
    localparam logic [7:0] NO_DATA   = 8'hFF;

endpackage

// File: rtl/jtframe_mister_upld.sv
// Serves HPS NVRAM upload reads from the core NVRAM with a request/ack handshake.
// hps_wait is high from the accepted hps_rd until one cycle after the core ack or timeout.
module jtframe_mister_upld
    import jtframe_mister_pkg::*;
#(
    parameter int         AW        = 13,
    parameter logic [7:0] IDX_NVRAM = jtframe_mister_pkg::IDX_NVRAM,
    parameter logic [7:0] TOUT      = 8'd255
)(
    input  logic          rst,
    input  logic          clk,
    input  logic          hps_upload,
    input  logic [7:0]    hps_index,
    input  logic          hps_rd,
    input  logic [26:0]   hps_addr,
    output logic [7:0]    hps_din,
    output logic          hps_wait,
    output logic          uploading,
    output logic [AW-1:0] nvram_addr,
    output logic          nvram_rd,
    input  logic          nvram_ack,
    input  logic [7:0]    nvram_dout,
    output logic          upld_done,
    output logic          upld_err
);

    typedef enum logic [1:0] { IDLE, REQ, DONE } state_t;

    state_t        state, state_nx;
    logic [7:0]    cnt, cnt_nx;
    logic [7:0]    din_nx;
    logic [AW-1:0] addr_nx;
    logic          rd_nx, wait_nx, err_nx, up_nx, in_range;

    assign up_nx    = hps_upload && (hps_index == IDX_NVRAM);
    assign in_range = (hps_addr >> AW) == 27'd0;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        din_nx   = hps_din;
        addr_nx  = nvram_addr;
        rd_nx    = nvram_rd;
        wait_nx  = hps_wait;
        err_nx   = upld_err;
        // A fresh upload session starts clean; a strobe during a busy cycle is flagged
        if (up_nx && !uploading)     err_nx = 1'b0;
        if (hps_rd && state != IDLE) err_nx = 1'b1;
        if (!uploading) begin
            state_nx = IDLE;
            rd_nx    = 1'b0;
            wait_nx  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hps_rd) begin
                        if (in_range) begin
                            addr_nx  = hps_addr[AW-1:0];
                            rd_nx    = 1'b1;
                            wait_nx  = 1'b1;
                            cnt_nx   = 8'd0;
                            state_nx = REQ;
                        end else begin
                            din_nx   = NO_DATA;
                        end
                    end
                end
                REQ: begin
                    // ack has priority over a timeout landing in the same cycle
                    if (nvram_ack) begin
                        din_nx   = nvram_dout;
                        rd_nx    = 1'b0;
                        state_nx = DONE;
                    end else if (cnt == TOUT) begin
                        din_nx   = NO_DATA;
                        err_nx   = 1'b1;
                        rd_nx    = 1'b0;
                        state_nx = DONE;
                    end else begin
                        cnt_nx   = cnt + 8'd1;
                    end
                end
                DONE: begin
                    wait_nx  = 1'b0;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            hps_din    <= NO_DATA;
            nvram_addr <= '0;
            nvram_rd   <= 1'b0;
            hps_wait   <= 1'b0;
            upld_err   <= 1'b0;
            uploading  <= 1'b0;
            upld_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            hps_din    <= din_nx;
            nvram_addr <= addr_nx;
            nvram_rd   <= rd_nx;
            hps_wait   <= wait_nx;
            upld_err   <= err_nx;
            uploading  <= up_nx;
            upld_done  <= uploading && !up_nx;
        end
    end

endmodule

// File: tb/tb_jtframe_mister_upld.sv
// Directed bench for jtframe_mister_upld: HPS read driver, core NVRAM responder
// and a scoreboard of expected hps_din bytes.
module tb_jtframe_mister_upld;
    import jtframe_mister_pkg::*;

    localparam int AW = 13;

    logic          rst, clk;
    logic          hps_upload, hps_rd, nvram_ack;
    logic [7:0]    hps_index, nvram_dout, hps_din;
    logic [26:0]   hps_addr;
    logic          hps_wait, uploading, nvram_rd, upld_done, upld_err;
    logic [AW-1:0] nvram_addr;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         rc, wc;
    bit         ok;

    jtframe_mister_upld #(.AW(AW), .IDX_NVRAM(8'h2), .TOUT(8'd255)) dut (
        .rst        (rst),
        .clk        (clk),
        .hps_upload (hps_upload),
        .hps_index  (hps_index),
        .hps_rd     (hps_rd),
        .hps_addr   (hps_addr),
        .hps_din    (hps_din),
        .hps_wait   (hps_wait),
        .uploading  (uploading),
        .nvram_addr (nvram_addr),
        .nvram_rd   (nvram_rd),
        .nvram_ack  (nvram_ack),
        .nvram_dout (nvram_dout),
        .upld_done  (upld_done),
        .upld_err   (upld_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: compare hps_din against the oldest expected byte
    task automatic sb_check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed empty queue expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, hps_din, e);
        end
    endtask

    // HPS read driver with core responder; ack_after=0 means the core never answers
    task automatic hps_read(input logic [26:0] addr, input int ack_after, input logic [7:0] data,
                            output int rd_cycles, output int wait_cycles, output bit addr_stable);
        hps_rd = 1'b1;
        hps_addr = addr;
        tick;
        hps_rd = 1'b0;
        rd_cycles = 0;
        wait_cycles = 0;
        addr_stable = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!hps_wait) break;
            wait_cycles++;
            if (nvram_rd) begin
                rd_cycles++;
                if (nvram_addr !== addr[AW-1:0]) addr_stable = 1'b0;
            end
            if (ack_after > 0 && nvram_rd && rd_cycles == ack_after) begin
                nvram_ack = 1'b1;
                nvram_dout = data;
            end
            tick;
            nvram_ack = 1'b0;
        end
        check("read_bounded", hps_wait, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        hps_upload = 1'b0;
        hps_index = 8'd0;
        hps_rd = 1'b0;
        hps_addr = 27'd0;
        nvram_ack = 1'b0;
        nvram_dout = 8'd0;
        repeat (3) tick;

        check("rst_din", hps_din, 8'hFF);
        check("rst_rd", nvram_rd, 1'b0);
        check("rst_wait", hps_wait, 1'b0);
        check("rst_uploading", uploading, 1'b0);
        check("rst_done", upld_done, 1'b0);
        check("rst_err", upld_err, 1'b0);
        check("rst_addr", nvram_addr, 13'd0);

        @(negedge clk);
        rst = 1'b0;
        tick;

        // upload of another index does not count as uploading; reads are ignored
        hps_upload = 1'b1;
        hps_index = IDX_ROM;
        tick;
        tick;
        check("wrong_idx_uploading", uploading, 1'b0);
        hps_rd = 1'b1;
        hps_addr = 27'h10;
        tick;
        hps_rd = 1'b0;
        check("idle_ignore_rd", nvram_rd, 1'b0);
        check("idle_ignore_wait", hps_wait, 1'b0);
        check("idle_ignore_din", hps_din, 8'hFF);

        hps_index = IDX_NVRAM;
        tick;
        check("uploading_rise", uploading, 1'b1);

        // basic read, ack after 3 cycles
        exp_q.push_back(8'h5A);
        hps_read(27'h10, 3, 8'h5A, rc, wc, ok);
        check("basic_rd_cycles", rc, 3);
        check("basic_wait_cycles", wc, 4);
        check("basic_addr_stable", ok, 1'b1);
        check("basic_addr", nvram_addr, 13'h10);
        sb_check("basic_din");
        check("basic_err", upld_err, 1'b0);

        // second strobe while busy flags an error but the first read completes
        hps_rd = 1'b1;
        hps_addr = 27'h123;
        tick;
        hps_rd = 1'b0;
        check("viol_req", nvram_rd, 1'b1);
        hps_rd = 1'b1;
        hps_addr = 27'h456;
        tick;
        hps_rd = 1'b0;
        check("viol_err", upld_err, 1'b1);
        check("viol_addr_kept", nvram_addr, 13'h123);
        nvram_ack = 1'b1;
        nvram_dout = 8'h3C;
        exp_q.push_back(8'h3C);
        tick;
        nvram_ack = 1'b0;
        check("viol_rd_low", nvram_rd, 1'b0);
        tick;
        check("viol_wait_low", hps_wait, 1'b0);
        sb_check("viol_din");

        // upload drops during REQ
        hps_rd = 1'b1;
        hps_addr = 27'h20;
        tick;
        hps_rd = 1'b0;
        check("drop_req", nvram_rd, 1'b1);
        hps_upload = 1'b0;
        tick;
        check("drop_done_pulse", upld_done, 1'b1);
        check("drop_uploading", uploading, 1'b0);
        tick;
        check("drop_rd", nvram_rd, 1'b0);
        check("drop_wait", hps_wait, 1'b0);
        check("drop_done_once", upld_done, 1'b0);
        nvram_ack = 1'b1;
        nvram_dout = 8'h77;
        tick;
        nvram_ack = 1'b0;
        check("late_ack_din", hps_din, 8'h3C);
        check("late_ack_rd", nvram_rd, 1'b0);
        check("err_sticky", upld_err, 1'b1);

        // new session clears the error
        hps_upload = 1'b1;
        tick;
        check("resume_uploading", uploading, 1'b1);
        check("err_cleared", upld_err, 1'b0);

        // out-of-range address
        exp_q.push_back(8'hFF);
        hps_read(27'h2000, 0, 8'h00, rc, wc, ok);
        check("oor_rd_cycles", rc, 0);
        check("oor_wait_cycles", wc, 0);
        sb_check("oor_din");

        // top in-range address, ack after 1 cycle
        exp_q.push_back(8'hC3);
        hps_read(27'h1FFF, 1, 8'hC3, rc, wc, ok);
        check("top_rd_cycles", rc, 1);
        check("top_wait_cycles", wc, 2);
        check("top_addr_stable", ok, 1'b1);
        sb_check("top_din");

        // ack in the very cycle the timeout would fire
        exp_q.push_back(8'h5E);
        hps_read(27'h0042, 256, 8'h5E, rc, wc, ok);
        check("race_rd_cycles", rc, 256);
        check("race_wait_cycles", wc, 257);
        check("race_err", upld_err, 1'b0);
        sb_check("race_din");

        // no ack: timeout
        exp_q.push_back(8'hFF);
        hps_read(27'h0ABC, 0, 8'h00, rc, wc, ok);
        check("tout_rd_cycles", rc, 256);
        check("tout_wait_cycles", wc, 257);
        check("tout_err", upld_err, 1'b1);
        sb_check("tout_din");

        // back in IDLE after the timeout
        exp_q.push_back(8'h99);
        hps_read(27'h0001, 2, 8'h99, rc, wc, ok);
        check("post_tout_rd_cycles", rc, 2);
        check("post_tout_wait_cycles", wc, 3);
        sb_check("post_tout_din");

        // asynchronous reset mid-REQ
        hps_rd = 1'b1;
        hps_addr = 27'h55;
        tick;
        hps_rd = 1'b0;
        check("arst_req", nvram_rd, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_din", hps_din, 8'hFF);
        check("arst_rd", nvram_rd, 1'b0);
        check("arst_wait", hps_wait, 1'b0);
        check("arst_uploading", uploading, 1'b0);
        check("arst_done", upld_done, 1'b0);
        check("arst_err", upld_err, 1'b0);
        check("arst_addr", nvram_addr, 13'd0);

        // release: no transaction resumes
        @(negedge clk);
        rst = 1'b0;
        tick;
        tick;
        check("rel_uploading", uploading, 1'b1);
        check("rel_rd", nvram_rd, 1'b0);
        check("rel_wait", hps_wait, 1'b0);
        check("rel_din", hps_din, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
